// File: rtl/y86_exec_pkg.sv
// Shared types for the Y86 execute stage: ALU function and condition codes,
// the condition-code register layout and its reset value.
package y86_exec_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,  // computes B - A
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_fun_e;

  typedef enum logic [2:0] {
    C_ALW = 3'd0,
    C_LE  = 3'd1,
    C_L   = 3'd2,
    C_E   = 3'd3,
    C_NE  = 3'd4,
    C_GE  = 3'd5,
    C_G   = 3'd6,
    C_RSV = 3'd7   // unused encoding, never true
  } cond_e;

  // Packed MSB-first so the struct maps directly onto {ZF,SF,OF}.
  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

endpackage

// File: rtl/y86_exec_cc_unit_cond_eval.sv
// Combinational jXX/cmovXX condition evaluator: condition codes + cond_e -> taken.
// Kept standalone so the decode stage can reuse it.
module y86_cond_eval
  import y86_exec_pkg::*;
(
  input  cc_t   cc,
  input  cond_e ifun,
  output logic  cnd
);

  // Evaluate the selected condition against the supplied flags.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves cnd unassigned (no latch).
    cnd = 1'b0;
    case (ifun)
      C_ALW:   cnd = 1'b1;
      C_LE:    cnd = (cc.sf ^ cc.of) | cc.zf;
      C_L:     cnd = cc.sf ^ cc.of;
      C_E:     cnd = cc.zf;
      C_NE:    cnd = !cc.zf;
      C_GE:    cnd = !(cc.sf ^ cc.of);
      C_G:     cnd = !(cc.sf ^ cc.of) & !cc.zf;
      default: cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/y86_exec_cc_unit.sv
// Execute-stage condition-code unit: derives ZF/SF/OF from the ALU result,
// holds the CC register, evaluates the branch/cmov condition from the CC value
// before this beat's update, and registers valE/cnd toward the memory stage
// through a one-entry valid/ready buffer.
// Optional build macro: EXEC_PERF_EN adds perf_ops/perf_taken counters.
module y86_exec_cc_unit
  import y86_exec_pkg::*;
#(
  parameter int W = 64
`ifdef EXEC_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [W-1:0]     in_res,
  input  logic [1:0]       in_fun,
  input  logic             in_set_cc,
  input  logic [2:0]       in_ifun,
  input  logic             cc_block,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_res,
  output logic             out_cnd,
  output logic [2:0]       out_cc
`ifdef EXEC_PERF_EN
  , output logic [CNT_W-1:0] perf_ops
  , output logic [CNT_W-1:0] perf_taken
`endif
);

  cc_t  cc;
  cc_t  beat_cc;
  logic beat_cnd;
  logic accept;

  // Only operand sign bits feed the overflow logic; the rest is intentionally ignored.
  logic unused_operand_bits;
  assign unused_operand_bits = ^{in_a[W-2:0], in_b[W-2:0]};

  // Buffer frees up when empty or when its beat drains this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign out_cc   = cc;

  // Flags of the incoming beat, taken from the supplied result.
  always_comb begin
    beat_cc    = '0;
    beat_cc.zf = (in_res == '0);
    beat_cc.sf = in_res[W-1];
    case (alu_fun_e'(in_fun))
      ALU_ADD: beat_cc.of = (in_a[W-1] == in_b[W-1]) && (in_res[W-1] != in_a[W-1]);
      ALU_SUB: beat_cc.of = (in_a[W-1] != in_b[W-1]) && (in_res[W-1] != in_b[W-1]);
      default: beat_cc.of = 1'b0;
    endcase
  end

  // Condition uses the CC register as it stands before this beat writes it.
  y86_cond_eval u_cond_eval (
    .cc   (cc),
    .ifun (cond_e'(in_ifun)),
    .cnd  (beat_cnd)
  );

  // Output buffer and CC register; reset drops any buffered beat.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_res   <= '0;
      out_cnd   <= 1'b0;
      cc        <= CC_RESET;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_res   <= in_res;
        out_cnd   <= beat_cnd;
        if (in_set_cc && !cc_block) begin
          cc <= beat_cc;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef EXEC_PERF_EN
  // Performance counters: accepted beats and beats whose condition was true.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops   <= '0;
      perf_taken <= '0;
    end else if (accept) begin
      perf_ops   <= perf_ops + 1'b1;
      perf_taken <= perf_taken + CNT_W'(beat_cnd);
    end
  end
`endif

endmodule
